// File: rtl/bcd_event_counter_7seg.sv
// N-digit BCD event counter with synchronised edge-detected input and 7-segment outputs.
// Supports up/down counting, wrap or saturate on overflow, segment polarity and leading-zero blanking.
module bcd_event_counter_7seg #(
    parameter int DIGITS         = 3,
    parameter bit WRAP           = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit BLANK_LZ       = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_num_i,
    input  logic                  i_up,
    input  logic                  i_clr,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [7*DIGITS-1:0]   o_seg,
    output logic                  o_of
);

    logic [2:0]          sync_q, sync_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic                of_q, of_d;
    logic [4*DIGITS-1:0] step_cnt;
    logic                carry;
    logic                event_pulse;

    assign event_pulse = sync_q[1] & ~sync_q[2];

    always_comb begin
        sync_d = {sync_q[1:0], i_num_i};
    end

    // Ripple one step through the digits; a carry/borrow out of the top digit means the range was exceeded.
    always_comb begin
        step_cnt = count_q;
        carry    = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (i_up) begin
                    if (count_q[4*k +: 4] == 4'd9) begin
                        step_cnt[4*k +: 4] = 4'd0;
                    end else begin
                        step_cnt[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (count_q[4*k +: 4] == 4'd0) begin
                        step_cnt[4*k +: 4] = 4'd9;
                    end else begin
                        step_cnt[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        of_d    = WRAP ? 1'b0 : of_q;
        if (i_clr) begin
            count_d = '0;
            of_d    = 1'b0;
        end else if (event_pulse) begin
            if (carry) begin
                // Saturating mode keeps the old value at the boundary.
                count_d = WRAP ? step_cnt : count_q;
                of_d    = 1'b1;
            end else begin
                count_d = step_cnt;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q  <= '0;
            count_q <= '0;
            of_q    <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            count_q <= count_d;
            of_q    <= of_d;
        end
    end

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_encode = 7'h3F;
            4'd1:    seg_encode = 7'h06;
            4'd2:    seg_encode = 7'h5B;
            4'd3:    seg_encode = 7'h4F;
            4'd4:    seg_encode = 7'h66;
            4'd5:    seg_encode = 7'h6D;
            4'd6:    seg_encode = 7'h7D;
            4'd7:    seg_encode = 7'h07;
            4'd8:    seg_encode = 7'h7F;
            4'd9:    seg_encode = 7'h6F;
            default: seg_encode = 7'h00;
        endcase
    endfunction

    // Walk from the top digit down so each digit knows whether everything above it is zero.
    always_comb begin
        logic       upper_zero;
        logic [6:0] pattern;
        o_seg      = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (count_q[4*k +: 4] == 4'd0);
            pattern    = seg_encode(count_q[4*k +: 4]);
            if (BLANK_LZ && (k != 0) && upper_zero) begin
                pattern = 7'h00;
            end
            o_seg[7*k +: 7] = SEG_ACTIVE_LOW ? ~pattern : pattern;
        end
    end

    assign o_bcd = count_q;
    assign o_of  = of_q;

endmodule

// File: tb/tb_bcd_event_counter_7seg.sv
// Drives three counter variants (wrap, saturate, active-low blanked) from one stimulus stream
// and compares them against an integer-arithmetic reference model.
module tb_bcd_event_counter_7seg;

    localparam int MAXV = 999;

    localparam int K_PULSE    = 0;
    localparam int K_CLR      = 1;
    localparam int K_HELD     = 2;
    localparam int K_CLR_EVT  = 3;
    localparam int K_GLITCH   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        num_i = 1'b0;
    logic        up = 1'b1;
    logic        clr = 1'b0;
    logic [11:0] bcd_w, bcd_s, bcd_l;
    logic [20:0] seg_w, seg_s, seg_l;
    logic        of_w_dut, of_s_dut, of_l_dut;

    int  n_checks = 0;
    int  n_fail = 0;
    int  cnt_w = 0;
    int  cnt_s = 0;
    bit  of_w = 1'b0;
    bit  of_s = 1'b0;

    always #5 clk = ~clk;

    bcd_event_counter_7seg #(.DIGITS(3), .WRAP(1'b1), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_num_i(num_i), .i_up(up), .i_clr(clr),
        .o_bcd(bcd_w), .o_seg(seg_w), .o_of(of_w_dut));

    bcd_event_counter_7seg #(.DIGITS(3), .WRAP(1'b0), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_num_i(num_i), .i_up(up), .i_clr(clr),
        .o_bcd(bcd_s), .o_seg(seg_s), .o_of(of_s_dut));

    bcd_event_counter_7seg #(.DIGITS(3), .WRAP(1'b1), .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) u_low (
        .i_clk(clk), .i_rst_n(rst_n), .i_num_i(num_i), .i_up(up), .i_clr(clr),
        .o_bcd(bcd_l), .o_seg(seg_l), .o_of(of_l_dut));

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r = '0;
        for (int k = 0; k < 3; k++) r[4*k +: 4] = 4'((v / (10 ** k)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  default: return 7'h6F;
        endcase
    endfunction

    // A digit above the units is a leading zero exactly when the whole value is below its weight.
    function automatic logic [20:0] seg_model(input int v, input bit active_low, input bit blank);
        logic [20:0] r;
        logic [6:0]  g;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            g = glyph((v / (10 ** k)) % 10);
            if (blank && k > 0 && v < 10 ** k) g = 7'h00;
            r[7*k +: 7] = active_low ? ~g : g;
        end
        return r;
    endfunction

    task automatic model_event(input bit dir_up);
        if (dir_up) begin
            if (cnt_w == MAXV) begin cnt_w = 0; of_w = 1'b1; end
            else cnt_w = cnt_w + 1;
            if (cnt_s == MAXV) of_s = 1'b1;
            else cnt_s = cnt_s + 1;
        end else begin
            if (cnt_w == 0) begin cnt_w = MAXV; of_w = 1'b1; end
            else cnt_w = cnt_w - 1;
            if (cnt_s == 0) of_s = 1'b1;
            else cnt_s = cnt_s - 1;
        end
    endtask

    task automatic model_clear();
        cnt_w = 0; cnt_s = 0; of_w = 1'b0; of_s = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, ".bcd_w"}, 32'(bcd_w), 32'(to_bcd(cnt_w)));
        checkOutput({tag, ".of_w"},  32'(of_w_dut), 32'(of_w));
        checkOutput({tag, ".seg_w"}, 32'(seg_w), 32'(seg_model(cnt_w, 1'b0, 1'b0)));
        checkOutput({tag, ".bcd_s"}, 32'(bcd_s), 32'(to_bcd(cnt_s)));
        checkOutput({tag, ".of_s"},  32'(of_s_dut), 32'(of_s));
        checkOutput({tag, ".seg_l"}, 32'(seg_l), 32'(seg_model(cnt_w, 1'b1, 1'b1)));
    endtask

    // Every stimulus starts and ends just after a falling edge.
    task automatic applyStimulus(input int kind, input bit dir_up, input int hold);
        int prev;
        bit ok;
        up = dir_up;
        case (kind)
            K_PULSE, K_CLR_EVT: begin
                prev = cnt_w;
                num_i = 1'b1;
                @(negedge clk);
                @(negedge clk);
                checkOutput("latency", 32'(bcd_w), 32'(to_bcd(prev)));
                num_i = 1'b0;
                if (kind == K_CLR_EVT) clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                if (kind == K_CLR_EVT) model_clear();
                else model_event(dir_up);
                checkState(kind == K_CLR_EVT ? "clr_evt" : "pulse");
                @(negedge clk);
                of_w = 1'b0;
                checkOutput("of_w_one_cycle", 32'(of_w_dut), 32'(of_w));
            end
            K_CLR: begin
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                model_clear();
                checkState("clr");
            end
            K_HELD: begin
                num_i = 1'b1;
                repeat (hold) @(negedge clk);
                num_i = 1'b0;
                repeat (3) @(negedge clk);
                model_event(dir_up);
                of_w = 1'b0;
                checkState("held");
            end
            default: begin
                prev = cnt_w;
                num_i = 1'b1;
                @(negedge clk);
                num_i = 1'b0;
                repeat (4) @(negedge clk);
                ok = (bcd_w == to_bcd(prev)) || (bcd_w == to_bcd((prev + 1) % (MAXV + 1)));
                checkOutput("glitch_once", 32'(ok), 32'd1);
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                model_clear();
                checkState("glitch_resync");
            end
        endcase
    endtask

    task automatic pulses(input int n, input bit dir_up);
        for (int i = 0; i < n; i++) applyStimulus(K_PULSE, dir_up, 0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        checkOutput("async_rst.bcd_w", 32'(bcd_w), 32'(to_bcd(0)));
        checkOutput("async_rst.bcd_s", 32'(bcd_s), 32'(to_bcd(0)));
        checkOutput("async_rst.of_s", 32'(of_s_dut), 32'd0);
        checkOutput("async_rst.seg_l", 32'(seg_l), 32'(seg_model(0, 1'b1, 1'b1)));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        repeat (3) @(negedge clk);
        checkState("reset");
        rst_n = 1'b1;
        @(negedge clk);

        pulses(5, 1'b1);
        checkOutput("five.bcd", 32'(bcd_w), 32'h005);
        pulses(994, 1'b1);
        checkState("at_max");
        pulses(1, 1'b1);
        pulses(1, 1'b0);
        pulses(3, 1'b1);
        applyStimulus(K_CLR, 1'b1, 0);

        applyStimulus(K_HELD, 1'b1, 50);
        applyStimulus(K_GLITCH, 1'b1, 0);

        pulses(42, 1'b1);
        applyStimulus(K_CLR_EVT, 1'b1, 0);

        pulses(123, 1'b1);
        checkOutput("pre_reset.bcd", 32'(bcd_w), 32'h123);
        async_reset();
        pulses(2, 1'b1);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5)       applyStimulus(K_PULSE, 1'b1, 0);
            else if (r < 8)  applyStimulus(K_PULSE, 1'b0, 0);
            else if (r == 8) applyStimulus(K_CLR, 1'b1, 0);
            else             applyStimulus(K_HELD, 1'($urandom_range(0, 1)), int'($urandom_range(2, 20)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_event_counter_7seg.md
Name: bcd_event_counter_7seg

Overview:
- Parametrised N-digit decimal event counter with per-digit 7-segment outputs and an overflow flag.
- Generalises the fixed 3-digit (hundreds/tens/units) pulse counter.
- Adds a synchroniser with edge detection on the event input, up/down counting, selectable wrap or saturate mode, segment polarity selection and a synchronous clear.
- Sits between a raw pulse source (button, sensor) and the board 7-segment displays.

Parameters:
- DIGITS, 3: number of BCD digits; count range is 0 .. 10^DIGITS-1 (supported range 1..6).
- WRAP, 1: 1 = wrap around with a one-cycle o_of pulse; 0 = saturate with o_of held set (sticky).
- SEG_ACTIVE_LOW, 0: 0 = segment on is 1 (common cathode); 1 = all segment bits inverted.
- BLANK_LZ, 0: 1 = leading zero digits drive all segments off; digit 0 is never blanked.

Ports:
- i_clk  in  1  system clock; all state on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_num_i  in  1  asynchronous event input; each rising edge is one event.
- i_up  in  1  count direction: 1 = increment, 0 = decrement; synchronous to i_clk.
- i_clr  in  1  synchronous clear; count and o_of go to 0.
- o_bcd  out  4*DIGITS  BCD count; digit k at [4k+3:4k], digit 0 = units.
- o_seg  out  7*DIGITS  segments; digit k at [7k+6:7k], bit order {g,f,e,d,c,b,a}.
- o_of  out  1  overflow/underflow flag, registered.

Behaviour:
- Reset (async assert, release on the clock): sync stages, edge register, count and o_of all 0.
  - o_seg shows "0" on every digit; with BLANK_LZ=1, digits 1..DIGITS-1 are off.
- Input path: two-FF synchroniser s1→s2, then s3 <= s2. Event pulse = s2 & ~s3.
- Latency: i_num_i is first sampled high at clock edge E. Count is updated at edge E+2, the edge where s3 captures. A level held high counts once.
- Minimum event spacing: 2 cycles high and 2 cycles low, guaranteed by the source. Narrower pulses may be missed; this is not an error.
- Count state is DIGITS BCD digits. No binary intermediate.
- Up: ripple-carry increment. A digit at 9 with carry-in becomes 0 and carries out.
- Down: ripple-borrow decrement. A digit at 0 with borrow becomes 9.
- i_up is sampled on the same edge the event is applied.
- Boundary, WRAP=1:
  - up at max (e.g. 999) → 000; o_of=1 for exactly one cycle, same edge as the wrap.
  - down at 000 → max; o_of pulses the same way.
- Boundary, WRAP=0:
  - up at max holds max and sets o_of; down at 000 holds 000 and sets o_of.
  - o_of stays 1 until i_clr or reset. Further events in range still count and do not clear o_of.
- Priority on any edge: reset > i_clr > event. An event arriving with i_clr is discarded.
- Non-event cycles: count holds. In WRAP=1, o_of returns to 0.
- Segment encoding, active-high, hex over {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - SEG_ACTIVE_LOW=1 inverts all bits.
  - o_seg is combinational from the count register. Zero added latency versus o_bcd.
- Leading-zero blanking: digit k>0 is blanked iff it and all higher digits are 0.
- Reset mid-sequence: the next event after release is counted from 0. No stale edge fires, because all sync stages are 0.

Test Plan:
- Reset, then 5 clean pulses (2 high / 2 low), i_up=1 → o_bcd=0x005, o_seg[6:0]=6D, o_seg[13:7]=3F, o_of=0. Each update lands 2 edges after i_num_i is first sampled high.
- WRAP=1, DIGITS=3: preload via 999 up-events, then 1 more → o_bcd=0x000, o_of high exactly 1 cycle. Then i_up=0 and 1 event → 0x999 with a second o_of pulse.
- WRAP=0: drive to 999, 3 more up-events → stays 0x999, o_of=1 sticky. Then i_up=0 and 1 event → 0x998, o_of still 1. Then i_clr → 0x000, o_of=0.
- i_num_i held high 50 cycles → count +1 only. A 1-cycle glitch on the input → either 0 or 1 counts, never 2.
- i_clr asserted on the same edge as an event, count 0x042 → 0x000. Async reset pulsed mid-count at 0x123 → 0x000 immediately, without waiting for a clock edge.
- SEG_ACTIVE_LOW=1, BLANK_LZ=1, count 7 → o_seg[6:0]=78, digits 1..2 = 7F (all off). At count 100 → digit 2=79, digits 1..0=40.
